// File: rtl/replay_buffer_param.sv
// Data-link-layer replay buffer: holds transmitted TLPs (data + sequence number) until an ACK
// covers them, replays outstanding entries on NAK or timeout, and requests retrain when too
// many replays happen without forward progress.
module replay_buffer_param #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned SEQ_W        = 12,
  parameter int unsigned REPLAY_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [SEQ_W-1:0]         seq,
  input  logic [DATA_W-1:0]        din,
  output logic                     ready,
  input  logic [1:0]               ack_nak,
  input  logic [SEQ_W-1:0]         ack_seq,
  input  logic                     timeout,
  output logic [DATA_W-1:0]        dout,
  output logic [SEQ_W-1:0]         dout_seq,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     replay_active,
  output logic                     retrain_req,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RN_W  = $clog2(REPLAY_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StPurge, StReplay} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d, rp_ptr_q, rp_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [RN_W-1:0]     replay_num_q, replay_num_d;
  logic                nak_pend_q, nak_pend_d;
  logic [SEQ_W-1:0]    ack_seq_q, ack_seq_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [SEQ_W-1:0]    dout_seq_q, dout_seq_d;
  logic                dout_valid_q, dout_valid_d;
  logic                retrain_q, retrain_d;

  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [SEQ_W-1:0]    seq_mem  [DEPTH];

  logic                push, pop, bump, load;
  logic [PTR_W-1:0]    load_ptr;
  logic [PTR_W-1:0]    newest_ptr;
  logic [SEQ_W-1:0]    seq_diff;
  logic                oldest_covered;

  assign ready      = (count_q < CNT_W'(DEPTH)) && (state_q != StReplay);
  assign push       = we && ready;
  assign newest_ptr = wr_ptr_q - PTR_W'(1);
  // Modulo compare: oldest entry is at or before the acked sequence number (with wrap).
  assign seq_diff       = ack_seq_q - seq_mem[rd_ptr_q];
  assign oldest_covered = ~seq_diff[SEQ_W-1];

  assign dout          = dout_q;
  assign dout_seq      = dout_seq_q;
  assign dout_valid    = dout_valid_q;
  assign replay_active = (state_q == StReplay);
  assign retrain_req   = retrain_q;
  assign count         = count_q;

  // Storage array; contents need no reset since occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= din;
      seq_mem[wr_ptr_q]  <= seq;
    end
  end

  // Next-state logic: DLLP handling, purge walk, replay streaming and replay-limit counting.
  always_comb begin
    state_d      = state_q;
    nak_pend_d   = nak_pend_q;
    ack_seq_d    = ack_seq_q;
    rd_ptr_d     = rd_ptr_q;
    rp_ptr_d     = rp_ptr_q;
    replay_num_d = replay_num_q;
    retrain_d    = 1'b0;
    dout_d       = dout_q;
    dout_seq_d   = dout_seq_q;
    dout_valid_d = dout_valid_q;
    pop          = 1'b0;
    bump         = 1'b0;
    load         = 1'b0;
    load_ptr     = rd_ptr_q;

    unique case (state_q)
      StIdle: begin
        // ACK/NAK win over a same-cycle timeout; reserved code 11 is ignored.
        if (ack_nak == 2'b01 || ack_nak == 2'b10) begin
          state_d    = StPurge;
          nak_pend_d = ack_nak[1];
          ack_seq_d  = ack_seq;
        end else if (timeout && count_q != '0) begin
          bump = 1'b1;
        end
      end
      StPurge: begin
        if (count_q != '0 && oldest_covered) begin
          pop          = 1'b1;
          replay_num_d = '0;
        end else if (nak_pend_q && count_q != '0) begin
          bump = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StReplay: begin
        if (dout_valid_q && dout_ready) begin
          if (rp_ptr_q == newest_ptr) begin
            dout_valid_d = 1'b0;
            state_d      = StIdle;
          end else begin
            rp_ptr_d = rp_ptr_q + PTR_W'(1);
            load     = 1'b1;
            load_ptr = rp_ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Start a replay from the oldest entry; the limit pulse does not stop the replay.
    if (bump) begin
      state_d      = StReplay;
      rp_ptr_d     = rd_ptr_q;
      load         = 1'b1;
      load_ptr     = rd_ptr_q;
      dout_valid_d = 1'b1;
      if (replay_num_q == RN_W'(REPLAY_LIMIT - 1)) begin
        replay_num_d = '0;
        retrain_d    = 1'b1;
      end else begin
        replay_num_d = replay_num_q + RN_W'(1);
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (load) begin
      dout_d     = data_mem[load_ptr];
      dout_seq_d = seq_mem[load_ptr];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rp_ptr_q     <= '0;
      count_q      <= '0;
      replay_num_q <= '0;
      nak_pend_q   <= 1'b0;
      ack_seq_q    <= '0;
      dout_q       <= '0;
      dout_seq_q   <= '0;
      dout_valid_q <= 1'b0;
      retrain_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_q     <= rd_ptr_d;
      rp_ptr_q     <= rp_ptr_d;
      count_q      <= count_d;
      replay_num_q <= replay_num_d;
      nak_pend_q   <= nak_pend_d;
      ack_seq_q    <= ack_seq_d;
      dout_q       <= dout_d;
      dout_seq_q   <= dout_seq_d;
      dout_valid_q <= dout_valid_d;
      retrain_q    <= retrain_d;
    end
  end

endmodule

// File: tb/tb_replay_buffer_param.sv
// Bench for replay_buffer_param: a queue-based model of the outstanding TLPs is checked
// against the DUT every cycle, plus literal expectations from directed scenarios.
module tb_replay_buffer_param;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int SEQ_W  = 12;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              we = 1'b0;
  logic [SEQ_W-1:0]  seq = '0;
  logic [DATA_W-1:0] din = '0;
  logic              ready;
  logic [1:0]        ack_nak = 2'b00;
  logic [SEQ_W-1:0]  ack_seq = '0;
  logic              timeout = 1'b0;
  logic [DATA_W-1:0] dout;
  logic [SEQ_W-1:0]  dout_seq;
  logic              dout_valid;
  logic              dout_ready = 1'b1;
  logic              replay_active;
  logic              retrain_req;
  logic [3:0]        count;

  replay_buffer_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W), .REPLAY_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .seq(seq), .din(din), .ready(ready),
    .ack_nak(ack_nak), .ack_seq(ack_seq), .timeout(timeout), .dout(dout),
    .dout_seq(dout_seq), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .replay_active(replay_active), .retrain_req(retrain_req), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int retrain_cnt = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [SEQ_W-1:0]  s;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];        // outstanding TLPs, oldest first
  int                m_mode;       // 0 idle, 1 purging, 2 replaying
  int                m_idx;        // queue index currently shown on the replay port
  int                m_rnum;
  bit                m_nak;
  int                m_aseq;
  bit                m_valid;
  bit                m_ret;
  logic [DATA_W-1:0] m_dout;
  logic [SEQ_W-1:0]  m_dseq;

  function automatic bit covered(int a, int s);
    int d;
    d = (a - s + (1 << SEQ_W)) % (1 << SEQ_W);
    return d < (1 << (SEQ_W - 1));
  endfunction

  task automatic m_show(input int i);
    m_idx  = i;
    m_dout = mq[i].d;
    m_dseq = mq[i].s;
  endtask

  task automatic m_start_replay();
    m_rnum++;
    if (m_rnum == LIMIT) begin
      m_rnum = 0;
      m_ret  = 1'b1;
    end
    m_mode  = 2;
    m_valid = 1'b1;
    m_show(0);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_mode = 0; m_idx = 0; m_rnum = 0; m_nak = 1'b0; m_aseq = 0;
      m_valid = 1'b0; m_ret = 1'b0; m_dout = '0; m_dseq = '0;
    end else begin
      int  sz;
      bit  rdy;
      sz    = mq.size();
      rdy   = (sz < DEPTH) && (m_mode != 2);
      m_ret = 1'b0;
      case (m_mode)
        0: begin
          if (ack_nak == 2'b01 || ack_nak == 2'b10) begin
            m_mode = 1; m_nak = (ack_nak == 2'b10); m_aseq = int'(ack_seq);
          end else if (timeout && sz > 0) begin
            m_start_replay();
          end
        end
        1: begin
          if (sz > 0 && covered(m_aseq, int'(mq[0].s))) begin
            void'(mq.pop_front());
            m_rnum = 0;
          end else if (m_nak && sz > 0) begin
            m_start_replay();
          end else begin
            m_mode = 0;
          end
        end
        default: begin
          if (dout_ready) begin
            if (m_idx == sz - 1) begin
              m_valid = 1'b0;
              m_mode  = 0;
            end else begin
              m_show(m_idx + 1);
            end
          end
        end
      endcase
      if (we && rdy) mq.push_back('{s: seq, d: din});
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      cmp("ready", ready, (mq.size() < DEPTH) && (m_mode != 2));
      cmp("count", count, mq.size());
      cmp("dout_valid", dout_valid, m_valid);
      cmp("replay_active", replay_active, m_mode == 2);
      cmp("retrain_req", retrain_req, m_ret);
      if (m_valid) begin
        cmp("dout", dout, m_dout);
        cmp("dout_seq", dout_seq, m_dseq);
      end
      if (retrain_req) retrain_cnt++;
    end
  end

  // ---------------- stimulus helpers (enter and leave on a falling edge) ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; we = 1'b0; ack_nak = 2'b00; timeout = 1'b0; dout_ready = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic wr(input int s, input logic [DATA_W-1:0] d);
    we = 1'b1; seq = SEQ_W'(s); din = d;
    tick(1);
    we = 1'b0;
  endtask

  task automatic dllp(input logic [1:0] code, input int s);
    ack_nak = code; ack_seq = SEQ_W'(s);
    tick(1);
    ack_nak = 2'b00;
  endtask

  task automatic tmo();
    timeout = 1'b1;
    tick(1);
    timeout = 1'b0;
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    for (int i = 0; i < 40 && dout_valid; i++) tick(1);
    if (dout_valid) cmp("drain_timeout", 1, 0);
    tick(1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !dout_valid; i++) tick(1);
    cmp("wait_valid", dout_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    tick(1);
    cmp("rst_ready", ready, 1);
    cmp("rst_valid", dout_valid, 0);
    cmp("rst_count", count, 0);
    cmp("rst_dout", dout, 0);
    cmp("rst_retrain", retrain_req, 0);
    reset_n = 1'b1;
    tick(1);

    // 1: four writes.
    for (int i = 0; i < 4; i++) wr(i, 64'(i));
    cmp("t1_count", count, 4);
    cmp("t1_valid", dout_valid, 0);

    // 2: ACK 1 purges two entries.
    dllp(2'b01, 1);
    tick(5);
    cmp("t2_count", count, 2);
    cmp("t2_active", replay_active, 0);

    // 3: NAK 1 purges 0,1 then replays 2,3 with back-pressure.
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, 64'(i));
    dout_ready = 1'b0;
    dllp(2'b10, 1);
    wait_valid();
    cmp("t3_seq0", dout_seq, 2);
    cmp("t3_dat0", dout, 2);
    cmp("t3_ready", ready, 0);
    tick(3);
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    cmp("t3_seq1", dout_seq, 3);
    tick(3);
    cmp("t3_hold_seq", dout_seq, 3);
    cmp("t3_hold_dat", dout, 3);
    drain();
    cmp("t3_count", count, 2);

    // 4: fill, overflow write ignored, timeout replays all eight.
    do_reset();
    for (int i = 0; i < 8; i++) wr(i, 64'hA0 + 64'(i));
    cmp("t4_ready", ready, 0);
    wr(8, 64'hFF);
    cmp("t4_count", count, 8);
    tmo();
    cmp("t4_first_seq", dout_seq, 0);
    cmp("t4_first_dat", dout, 64'hA0);
    drain();
    cmp("t4_count_after", count, 8);

    // 5: replay limit, then ACK clears progress counter.
    do_reset();
    retrain_cnt = 0;
    for (int i = 0; i < 8; i++) wr(i, 64'hB0 + 64'(i));
    for (int k = 0; k < 4; k++) begin
      tmo();
      drain();
    end
    cmp("t5_retrain", retrain_cnt, 1);
    dllp(2'b01, 0);
    tick(4);
    cmp("t5_count", count, 7);
    for (int k = 0; k < 2; k++) begin
      tmo();
      drain();
    end
    dllp(2'b01, 1);
    tick(4);
    cmp("t5_count2", count, 6);
    for (int k = 0; k < 3; k++) begin
      tmo();
      drain();
    end
    cmp("t5_retrain_cleared", retrain_cnt, 1);

    // 6: sequence wrap, then async reset mid-replay.
    do_reset();
    wr(4094, 64'h10);
    wr(4095, 64'h11);
    wr(0, 64'h12);
    wr(1, 64'h13);
    dllp(2'b01, 0);
    tick(6);
    cmp("t6_count", count, 1);
    dout_ready = 1'b0;
    tmo();
    cmp("t6_seq", dout_seq, 1);
    cmp("t6_dat", dout, 64'h13);
    #2 reset_n = 1'b0;
    #1;
    cmp("t6_rst_valid", dout_valid, 0);
    cmp("t6_rst_count", count, 0);
    cmp("t6_rst_ready", ready, 1);
    cmp("t6_rst_active", replay_active, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dout_ready = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
